// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute-side units:
// opcodes, funct codes, ALU operation codes and funct decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  typedef struct packed {
    logic       ok;
    logic [2:0] op;
  } fdec_t;

  function automatic fdec_t funct_dec(
    input logic [5:0] f
  );
    fdec_t d;
    d = '{ok: 1'b1, op: ALU_ADD};
    case (f)
      FN_ADD:  d.op = ALU_ADD;
      FN_SUB:  d.op = ALU_SUB;
      FN_AND:  d.op = ALU_AND;
      FN_OR:   d.op = ALU_OR;
      FN_XOR:  d.op = ALU_XOR;
      FN_NOR:  d.op = ALU_NOR;
      FN_SLT:  d.op = ALU_SLT;
      FN_SLTU: d.op = ALU_SLTU;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: combinational read,
// clocked write, asynchronous clear of every word.
module dmem_array #(
  parameter int DMEM_WORDS = 64,
  localparam int AW = $clog2(DMEM_WORDS)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  input  logic          we,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DMEM_WORDS];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mips_exec_units.sv
// ID-stage decoder, EX-stage ALU and MEM-stage data memory.
// Decode and ALU are pure combinational paths.
module mips_exec_units #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        RegWre,
  output logic        DBDataSrc,
  output logic        mWR,
  output logic        ALUSrcB,
  output logic        RegDst,
  output logic [2:0]  ALUOp,
  input  logic [2:0]  alu_op,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  input  logic        WR,
  output logic [31:0] DataOut
);
  import mips_pkg::*;

  localparam int AW = $clog2(DMEM_WORDS);

  fdec_t fd;

  assign fd = funct_dec(funct);

  always_comb begin
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    mWR       = 1'b0;
    ALUSrcB   = 1'b0;
    RegDst    = 1'b0;
    ALUOp     = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (fd.ok) begin
          RegWre = 1'b1;
          RegDst = 1'b1;
          ALUOp  = fd.op;
        end
      end
      OP_ADDI: begin
        RegWre  = 1'b1;
        ALUSrcB = 1'b1;
      end
      OP_SLTI: begin
        RegWre  = 1'b1;
        ALUSrcB = 1'b1;
        ALUOp   = ALU_SLT;
      end
      OP_LW: begin
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        ALUSrcB   = 1'b1;
      end
      OP_SW: begin
        mWR     = 1'b1;
        ALUSrcB = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_NOR:  alu_result = ~(alu_a | alu_b);
      ALU_SLT:  alu_result = {31'd0,
        $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // Byte-offset and high address bits are dropped: addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{DAddr[31:AW+2], DAddr[1:0]};

  dmem_array #(
    .DMEM_WORDS(DMEM_WORDS)
  ) u_dmem (
    .clk   (clk),
    .Reset (Reset),
    .index (DAddr[AW+1:2]),
    .wdata (DataIn),
    .we    (WR),
    .rdata (DataOut)
  );

endmodule

// File: tb/tb_mips_exec_units.sv
// Randomized self-checking bench for mips_exec_units
// against a behavioural decode/ALU/memory model.
module tb_mips_exec_units;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        Reset;
  logic [5:0]  opcode, funct;
  logic        RegWre, DBDataSrc, mWR;
  logic        ALUSrcB, RegDst;
  logic [2:0]  ALUOp, alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic [31:0] DAddr, DataIn, DataOut;
  logic        WR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [W];

  always #5 clk = ~clk;

  mips_exec_units #(.DMEM_WORDS(W)) dut (
    .clk(clk), .Reset(Reset),
    .opcode(opcode), .funct(funct),
    .RegWre(RegWre), .DBDataSrc(DBDataSrc),
    .mWR(mWR), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .ALUOp(ALUOp),
    .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .DAddr(DAddr),
    .DataIn(DataIn), .WR(WR),
    .DataOut(DataOut)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
        tag, got, exp);
    end
  endtask

  // {RegWre,DBDataSrc,mWR,ALUSrcB,RegDst,ALUOp}
  function automatic logic [7:0] ref_dec(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic [5:0] rfn [8];
    rfn = '{6'd32, 6'd34, 6'd36, 6'd37,
            6'd38, 6'd39, 6'd42, 6'd43};
    if (op == 6'd0) begin
      for (int i = 0; i < 8; i++)
        if (fn == rfn[i])
          return {5'b10001, 3'(i)};
      return 8'h00;
    end
    if (op == 6'd8)  return 8'b10010_000;
    if (op == 6'd10) return 8'b10010_110;
    if (op == 6'd35) return 8'b11010_000;
    if (op == 6'd43) return 8'b00110_000;
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 32'(a + b);
      3'd1: return 32'(a - b);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return (sa < sb) ? 32'd1 : 32'd0;
      default:
        return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ctl();
    return {24'd0, RegWre, DBDataSrc, mWR,
            ALUSrcB, RegDst, ALUOp};
  endfunction

  task automatic alu_chk(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] e;
    alu_op = op; alu_a = a; alu_b = b;
    #1;
    e = ref_alu(op, a, b);
    chk(tag, alu_result, e);
    chk({tag, "_z"}, {31'd0, alu_zero},
        {31'd0, e == 32'd0});
  endtask

  // Drives one memory cycle from a negedge.
  task automatic mem_cyc(
    input logic [31:0] addr,
    input logic [31:0] d,
    input logic        we
  );
    int idx;
    idx = int'((addr >> 2) % W);
    @(negedge clk);
    DAddr = addr; DataIn = d; WR = we;
    #1;
    chk("mem_pre", DataOut, ref_mem[idx]);
    @(posedge clk);
    if (we && Reset) ref_mem[idx] = d;
    #1;
    chk("mem_post", DataOut, ref_mem[idx]);
  endtask

  task automatic mem_rd(
    input string       tag,
    input logic [31:0] addr,
    input logic [31:0] exp
  );
    DAddr = addr; WR = 1'b0;
    #1;
    chk(tag, DataOut, exp);
  endtask

  logic [19:0] dtab [14];
  logic [31:0] edge_v [6];

  initial begin
    dtab = '{
      {6'h00, 6'h20, 8'b10001_000},
      {6'h00, 6'h22, 8'b10001_001},
      {6'h00, 6'h24, 8'b10001_010},
      {6'h00, 6'h25, 8'b10001_011},
      {6'h00, 6'h26, 8'b10001_100},
      {6'h00, 6'h27, 8'b10001_101},
      {6'h00, 6'h2A, 8'b10001_110},
      {6'h00, 6'h2B, 8'b10001_111},
      {6'h08, 6'h15, 8'b10010_000},
      {6'h0A, 6'h00, 8'b10010_110},
      {6'h23, 6'h3F, 8'b11010_000},
      {6'h2B, 6'h20, 8'b00110_000},
      {6'h3F, 6'h20, 8'b00000_000},
      {6'h00, 6'h01, 8'b00000_000}
    };
    edge_v = '{32'h0, 32'h1, 32'h7FFFFFFF,
               32'h80000000, 32'hFFFFFFFF,
               32'hFFFFFFFE};
    for (int i = 0; i < W; i++) ref_mem[i] = '0;

    Reset = 1'b0; WR = 1'b0;
    DAddr = '0; DataIn = '0;
    opcode = '0; funct = '0;
    alu_op = '0; alu_a = '0; alu_b = '0;
    #2;
    chk("rst_dout", DataOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;

    foreach (dtab[i]) begin
      opcode = dtab[i][19:14];
      funct  = dtab[i][13:8];
      #1;
      chk($sformatf("dec_%02h_%02h",
          opcode, funct),
          ctl(), {24'd0, dtab[i][7:0]});
    end
    repeat (300) begin
      case ($urandom_range(0, 2))
        0: opcode = 6'd0;
        1: opcode = 6'($urandom_range(0, 5) * 7 + 8);
        default: opcode = 6'($urandom);
      endcase
      funct = ($urandom_range(0, 1) == 0)
        ? 6'($urandom_range(32, 43))
        : 6'($urandom);
      #1;
      chk("dec_rand", ctl(),
          {24'd0, ref_dec(opcode, funct)});
    end

    alu_chk("add_ovf", 3'd0, 32'h7FFFFFFF, 32'd1);
    chk("add_ovf_v", alu_result, 32'h80000000);
    alu_chk("add_wrap", 3'd0, 32'hFFFFFFFF, 32'd1);
    chk("add_wrap_z", {31'd0, alu_zero}, 32'd1);
    alu_chk("sub", 3'd1, 32'd5, 32'd7);
    chk("sub_v", alu_result, 32'hFFFFFFFE);
    alu_chk("slt", 3'd6, 32'hFFFFFFFF, 32'd1);
    chk("slt_v", alu_result, 32'd1);
    alu_chk("sltu", 3'd7, 32'hFFFFFFFF, 32'd1);
    chk("sltu_v", alu_result, 32'd0);
    alu_chk("nor", 3'd5, 32'd0, 32'd0);
    chk("nor_v", alu_result, 32'hFFFFFFFF);
    repeat (400) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0)
        ? edge_v[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0)
        ? edge_v[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      alu_chk("alu_rand", 3'($urandom), a, b);
    end

    mem_cyc(32'h8, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    mem_rd("rd_08", 32'h8, 32'hDEADBEEF);
    mem_rd("rd_0b", 32'hB, 32'hDEADBEEF);
    mem_rd("rd_108", 32'h108, 32'hDEADBEEF);
    mem_rd("rd_0c", 32'hC, 32'd0);
    repeat (400) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 3) == 0)
        ad = {24'($urandom), 8'h10};
      mem_cyc(ad, $urandom,
        $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 4; i++)
      mem_cyc(32'(i * 4 + 64), 32'hA5A50000 + i, 1'b1);
    @(negedge clk);
    DAddr = 32'h44; DataIn = 32'h12345678;
    WR = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_now", DataOut, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_edge", DataOut, 32'd0);
    @(negedge clk);
    WR = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < W; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++)
      mem_rd("rst_clr", 32'(i * 4 + 64), 32'd0);
    mem_rd("rst_clr8", 32'h8, 32'd0);
    mem_cyc(32'h44, 32'hCAFEF00D, 1'b1);
    chk("post_rst_wr", DataOut, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_units.md
# mips_exec_units

Combinational instruction decoder, 32-bit ALU and word-addressed data memory for the 5-stage MIPS pipeline. Decode sits in the ID stage, the ALU in EX and the memory in MEM. The three paths are independent: the pipeline registers between stages live outside this block. Only the memory holds state.

## Interface
Parameters:
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).

Ports:
- clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- opcode  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- RegWre  output  1  register-file write enable
- DBDataSrc  output  1  writeback source: 0 = ALU result, 1 = memory data
- mWR  output  1  data memory write enable
- ALUSrcB  output  1  ALU B source: 0 = rt data, 1 = sign-extended immediate
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- ALUOp  output  3  ALU operation selected by decode
- alu_op  input  3  ALU operation for the EX stage
- alu_a  input  32  ALU operand A
- alu_b  input  32  ALU operand B
- alu_result  output  32  ALU result
- alu_zero  output  1  high when alu_result == 0
- DAddr  input  32  byte address
- DataIn  input  32  store data
- WR  input  1  store enable
- DataOut  output  32  load data

## Operation
ALUOp and alu_op encoding:

| Code | Operation |
|------|-----------|
| 000 | add |
| 001 | sub |
| 010 | and |
| 011 | or |
| 100 | xor |
| 101 | nor |
| 110 | slt (signed) |
| 111 | sltu |

- add and sub wrap modulo 2^32. No overflow trap.
- slt and sltu return 32'd1 or 32'd0.

Decode (each listed instruction gives RegWre, DBDataSrc, mWR, ALUSrcB, RegDst, ALUOp):
- opcode 000000 is R-type. RegWre=1, RegDst=1, ALUSrcB=0, DBDataSrc=0, mWR=0. funct selects ALUOp:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 100110 → xor
  - 100111 → nor
  - 101010 → slt
  - 101011 → sltu
- An unlisted funct with opcode 000000 is treated as a NOP.
- addi (001000): 1,0,0,1,0,add
- slti (001010): 1,0,0,1,0,slt
- lw (100011): 1,1,0,1,0,add
- sw (101011): 0,0,1,1,0,add
- Any other opcode is a NOP: all enables 0, ALUSrcB=0, RegDst=0, DBDataSrc=0, ALUOp=add.

Data memory:
- Word index = DAddr[log2(DMEM_WORDS)+1:2].
- DAddr[1:0] and the upper address bits are ignored, so addresses wrap modulo the memory size.
- Reads are combinational: DataOut = mem[index].
- Writes: mem[index] <= DataIn on the rising edge of clk when WR=1 and Reset=1.

## Timing
- Decode and ALU have zero latency. Their outputs are pure functions of the current inputs and are unaffected by Reset.
- A store becomes visible on DataOut right after the write edge.
  - Same-cycle read-before-write: DataOut shows the old word until the edge.
- Reset low clears every memory word to 0 immediately, without waiting for a clock edge. DataOut reads 0 while Reset is held low.
- Writes are ignored while Reset=0.
- Reset asserted during a write cycle leaves all words 0 after the edge.
- Writes resume on the first rising edge after Reset deasserts.
- Consecutive writes to the same index: the last one wins.
- Writes to different indices in consecutive cycles do not disturb each other.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW
  - funct constants
  - ALUOp codes ALU_ADD..ALU_SLTU
- Decode and ALU are flat combinational logic inside the top module.
- The memory array is one sub-module, dmem_array (clk, Reset, index, wdata, we, rdata), parameterised by DMEM_WORDS.

## Test plan
- Decode sweep: drive each listed opcode/funct, plus opcode 111111 and R-type funct 000001.
  - Required: the exact control vectors above.
  - The two unlisted cases must decode as NOP with all enables 0.
- ALU arithmetic, with alu_op=add:
  - 0x7FFFFFFF+1 → 0x80000000
  - 0xFFFFFFFF+1 → 0, alu_zero=1
- ALU sub: 5−7 → 0xFFFFFFFE.
- ALU compare and logic with a=0xFFFFFFFF, b=1:
  - slt → 1
  - sltu → 0
  - nor of 0 and 0 → 0xFFFFFFFF
- Memory:
  - Write 0xDEADBEEF to DAddr 0x8, then read DAddr 0x8, 0xB and 0x108 → 0xDEADBEEF.
  - Read DAddr 0xC → 0.
- Reset:
  - Fill several words, pull Reset low mid-cycle with WR=1; DataOut → 0 immediately.
  - After release, all previously written addresses read 0.
  - The first post-reset write succeeds.
